// File: rtl/obi_arb_pkg.sv
// ---------------------------------------------------------------------------
// obi_arb_pkg
// Shared types and widths for the OBI instruction/data arbiter.
//   obi_src_e : identifies which core port issued a transfer
//   OBI_AW    : address width
//   OBI_DW    : data width
//   OBI_BEW   : byte-enable width
// ---------------------------------------------------------------------------
package obi_arb_pkg;

    typedef enum logic {
        SRC_INSTR,
        SRC_DATA
    } obi_src_e;

    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = 4;

endpackage

// File: rtl/obi_src_fifo.sv
// ---------------------------------------------------------------------------
// obi_src_fifo
// Depth-MAX_OUT FIFO holding the source of every granted transfer, so that
// in-order responses can be steered back to the port that issued them.
// Ports:
//   hclk_i, hresetn_i : clock, asynchronous active-low reset
//   push, din         : write one entry
//   pop               : discard the head entry
//   head              : current head entry
//   count             : number of stored entries (0..MAX_OUT)
//   full, empty       : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module obi_src_fifo
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic                         hclk_i,
    input  logic                         hresetn_i,
    input  logic                         push,
    input  obi_src_e                     din,
    input  logic                         pop,
    output obi_src_e                     head,
    output logic [$clog2(MAX_OUT+1)-1:0] count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    obi_src_e         mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at MAX_OUT, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(MAX_OUT));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says valid.
    always_ff @(posedge hclk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/obi_ifetch_data_arbiter.sv
// ---------------------------------------------------------------------------
// obi_ifetch_data_arbiter
// Shares one OBI-to-AHB-Lite adapter between the CV32E40P instruction-fetch
// and data OBI ports.
// Ports:
//   hclk_i, hresetn_i           : clock, asynchronous active-low reset
//   instr_req/gnt/addr          : instruction address phase
//   instr_rvalid/rdata/err      : instruction response
//   data_req/gnt/we/be/addr/wdata : data address phase
//   data_rvalid/rdata/err       : data response
//   m_req/gnt/we/be/addr/wdata  : request toward the adapter
//   m_rvalid/rdata/err          : response from the adapter
//   m_pending_o                 : outstanding limit reached (adapter hint)
//   unexp_rsp_o                 : sticky, response seen with nothing pending
// Parameters:
//   MAX_OUT    : granted-but-unanswered transfers allowed (1..4)
//   FIXED_PRIO : 0 = round-robin, 1 = data port always wins a tie
// ---------------------------------------------------------------------------
module obi_ifetch_data_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUT    = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic               hclk_i,
    input  logic               hresetn_i,

    input  logic               instr_req_i,
    output logic               instr_gnt_o,
    input  logic [OBI_AW-1:0]  instr_addr_i,
    output logic               instr_rvalid_o,
    output logic [OBI_DW-1:0]  instr_rdata_o,
    output logic               instr_err_o,

    input  logic               data_req_i,
    output logic               data_gnt_o,
    input  logic               data_we_i,
    input  logic [OBI_BEW-1:0] data_be_i,
    input  logic [OBI_AW-1:0]  data_addr_i,
    input  logic [OBI_DW-1:0]  data_wdata_i,
    output logic               data_rvalid_o,
    output logic [OBI_DW-1:0]  data_rdata_o,
    output logic               data_err_o,

    output logic               m_req_o,
    input  logic               m_gnt_i,
    output logic               m_we_o,
    output logic [OBI_BEW-1:0] m_be_o,
    output logic [OBI_AW-1:0]  m_addr_o,
    output logic [OBI_DW-1:0]  m_wdata_o,
    input  logic               m_rvalid_i,
    input  logic [OBI_DW-1:0]  m_rdata_i,
    input  logic               m_err_i,

    output logic               m_pending_o,
    output logic               unexp_rsp_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    obi_src_e         fifo_head;

    logic             pop;
    logic             push;
    logic             slot_free;
    logic             instr_elig;
    logic             data_elig;
    logic             lock_valid;
    obi_src_e         sel;

    logic             lock_q;
    obi_src_e         lock_src_q;
    obi_src_e         rr_last_q;
    logic             unexp_q;

    obi_src_fifo #(
        .MAX_OUT (MAX_OUT)
    ) u_src_fifo (
        .hclk_i    (hclk_i),
        .hresetn_i (hresetn_i),
        .push      (push),
        .din       (sel),
        .pop       (pop),
        .head      (fifo_head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A response arriving this cycle frees its slot immediately, so a full
    // FIFO can still accept a new grant in the same cycle.
    assign pop        = m_rvalid_i & ~fifo_empty;
    assign slot_free  = ~fifo_full | pop;
    assign instr_elig = instr_req_i & slot_free;
    assign data_elig  = data_req_i & slot_free;
    assign m_req_o    = instr_elig | data_elig;
    assign push       = m_req_o & m_gnt_i;

    // The lock only steers selection while its holder is still requesting;
    // a holder that withdrew (illegal OBI) must not be granted.
    assign lock_valid = lock_q & ((lock_src_q == SRC_INSTR) ? instr_elig : data_elig);

    always_comb begin
        sel = SRC_DATA;
        if (lock_valid) begin
            sel = lock_src_q;
        end else if (instr_elig && !data_elig) begin
            sel = SRC_INSTR;
        end else if (data_elig && !instr_elig) begin
            sel = SRC_DATA;
        end else if (FIXED_PRIO != 0) begin
            sel = SRC_DATA;
        end else begin
            sel = (rr_last_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        end
    end

    // Request fields are driven to zero when nothing is requested.
    always_comb begin
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        if (m_req_o) begin
            if (sel == SRC_DATA) begin
                m_we_o    = data_we_i;
                m_be_o    = data_be_i;
                m_addr_o  = data_addr_i;
                m_wdata_o = data_wdata_i;
            end else begin
                m_be_o    = '1;
                m_addr_o  = instr_addr_i;
            end
        end
    end

    assign instr_gnt_o    = push & (sel == SRC_INSTR);
    assign data_gnt_o     = push & (sel == SRC_DATA);

    assign instr_rvalid_o = pop & (fifo_head == SRC_INSTR);
    assign data_rvalid_o  = pop & (fifo_head == SRC_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? m_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o & m_err_i;
    assign data_rdata_o   = data_rvalid_o ? m_rdata_i : '0;
    assign data_err_o     = data_rvalid_o & m_err_i;

    assign m_pending_o    = (count == CNT_W'(MAX_OUT)) & ~m_rvalid_i;
    assign unexp_rsp_o    = unexp_q;

    // Lock follows any stalled request and drops on the handshake or when
    // no request is offered; rr_last tracks the most recent winner.
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
            rr_last_q  <= SRC_INSTR;
            unexp_q    <= 1'b0;
        end else begin
            if (m_req_o && !m_gnt_i) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel;
            end else begin
                lock_q     <= 1'b0;
            end
            if (push) begin
                rr_last_q <= sel;
            end
            if (m_rvalid_i && fifo_empty) begin
                unexp_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/obi_ifetch_data_arbiter.md
# obi_ifetch_data_arbiter

Two-to-one OBI arbiter that shares a single OBI-to-AHB-Lite master adapter between the CV32E40P instruction-fetch and data ports. It selects one requester per address phase, forwards it to the adapter, and records the source of every granted transfer in an order FIFO. Responses from the adapter are returned to the port that issued them. It sits between the core's OBI ports and the adapter's `data_*` interface, and drives the adapter's `pending_dbus_xfer_i`.

## Interface
Parameters:
- `MAX_OUT`, default 2: maximum granted-but-unanswered transfers; legal values 1..4.
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 gives the data port fixed priority.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `hclk_i` in 1: clock.
- `hresetn_i` in 1: asynchronous reset, active-low.
- `instr_req_i` in 1, `instr_gnt_o` out 1, `instr_addr_i` in 32: instruction-port address phase.
- `instr_rvalid_o` out 1, `instr_rdata_o` out 32, `instr_err_o` out 1: instruction-port response.
- `data_req_i` in 1, `data_gnt_o` out 1, `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32: data-port address phase.
- `data_rvalid_o` out 1, `data_rdata_o` out 32, `data_err_o` out 1: data-port response.
- `m_req_o` out 1, `m_gnt_i` in 1, `m_we_o` out 1, `m_be_o` out 4, `m_addr_o` out 32, `m_wdata_o` out 32: request toward the adapter.
- `m_rvalid_i` in 1, `m_rdata_i` in 32, `m_err_i` in 1: response from the adapter.
- `m_pending_o` out 1: drives the adapter's `pending_dbus_xfer_i`.
- `unexp_rsp_o` out 1: sticky flag for a response that arrives with no transfer outstanding.

## Operation
- **Eligibility.** A port is eligible when its `req` is high and the FIFO is not full. `m_req_o` is the OR of the eligible ports.
- **Selection.** If `lock` is set, the locked source wins. Otherwise, with a single eligible port, that port wins. With both eligible: when `FIXED_PRIO`=1 the data port wins; when `FIXED_PRIO`=0 the port not recorded in `rr_last` wins.
- **Instruction forwarding.** When the instruction port is selected, `m_we_o`=0, `m_be_o`=4'hF, `m_addr_o`=`instr_addr_i`, and `m_wdata_o`=0.
- **Data forwarding.** When the data port is selected, all `m_*` request fields pass `data_*` through.
- **Grant.** `x_gnt_o` = `m_gnt_i` AND `m_req_o` AND (selected == x). At most one grant is high per cycle.
- **Lock.** Set when `m_req_o`=1 and `m_gnt_i`=0; it holds the selected source. Cleared on the handshake. This keeps the downstream address stable, as OBI requires.
- **Handshake.** On `m_req_o` and `m_gnt_i`: push the source ID (0 = instr, 1 = data) into the FIFO, then update `rr_last` to that source.
- **Response routing.** When `m_rvalid_i` is high, the FIFO head selects which of `instr_rvalid_o`/`data_rvalid_o` pulses. Rdata and err are routed to that port; the other port's rdata and err read 0. The head is then popped.
- **Counter.** `count` covers 0..MAX_OUT. A push and pop in the same cycle leave `count` unchanged.
- **Pending output.** `m_pending_o` = (`count`==MAX_OUT) AND NOT `m_rvalid_i`.
- **Unexpected response.** `m_rvalid_i` with `count`==0: the response is dropped, no rvalid is issued, and `unexp_rsp_o` is set. It stays set until reset.

## Timing
- **Reset values.** All outputs are 0. FIFO empty, `count`=0, `lock`=0, and `rr_last`=instr, so the data port wins the first tie.
- **Request path.** Grant and request forwarding are combinational, with zero added latency.
- **Response path.** `m_rvalid_i` to `x_rvalid_o` is combinational, with zero added latency.
- **Same-cycle pop and push.** A pop and push in one cycle are legal at `count`==MAX_OUT. The pop frees the slot combinationally, so the push is accepted.
- **Reset mid-transfer.** Reset clears all state. Any in-flight response that arrives afterwards is treated as unexpected.
- **Requester drops request.** If a locked requester drops `req` before grant (illegal under OBI), the lock clears the next cycle. No push occurs.

## Structure
- Package `obi_arb_pkg` contains:
  - `typedef enum logic {SRC_INSTR, SRC_DATA} obi_src_e`.
  - The width constants `OBI_AW`=32, `OBI_DW`=32, `OBI_BEW`=4.
- Sub-module `obi_src_fifo`: a parameterised depth-`MAX_OUT` FIFO of `obi_src_e`. It provides push, pop, head, count, full and empty, and has an asynchronous active-low reset.

## Test plan
- **Single requester.** Instr req at 0x100 with the adapter granting. Expect `instr_gnt_o`=1 and `m_addr_o`=0x100, `m_be_o`=F, `m_we_o`=0. A later `m_rvalid_i` with rdata 0xDEADBEEF gives `instr_rvalid_o`=1 and `instr_rdata_o`=0xDEADBEEF.
- **Tie after reset (`FIXED_PRIO`=0).** Both ports request with `m_gnt_i`=1 held. Expect grant order data, instr, data, instr.
- **Stall lock.** Data req is presented with `m_gnt_i`=0 for 3 cycles, and instr req rises in cycle 1. Expect `m_addr_o` to stay equal to the data address until the grant, and instr to be granted next.
- **Full FIFO (`MAX_OUT`=2).** Two grants with no response. Expect `m_req_o`=0 and `m_pending_o`=1. When `m_rvalid_i` arrives together with a new req, expect the grant in the same cycle and `count` to remain 2.
- **Ordering and error.** Issue instr, data, instr, then 3 responses, the second with `m_err_i`=1. Expect rvalid on instr, data, instr in that order, and `data_err_o`=1 only on the second.
- **Unexpected response.** `m_rvalid_i` with nothing outstanding: no rvalid on either port, and `unexp_rsp_o`=1 until reset.
